// File: rtl/division_arbiter.sv
// Round-robin arbiter that shares one DivisionUnit among NUM_REQ requesters,
// with local divide-by-zero handling and a watchdog on unit completion.
module division_arbiter #(
  parameter int WORD_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_left,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_right,
  output logic [NUM_REQ-1:0]            resp_valid,
  input  logic [NUM_REQ-1:0]            resp_ready,
  output logic [WORD_WIDTH-1:0]         resp_quot,
  output logic [WORD_WIDTH-1:0]         resp_mod,
  output logic [1:0]                    resp_err,
  output logic                          div_enable,
  output logic [WORD_WIDTH-1:0]         div_left_op,
  output logic [WORD_WIDTH-1:0]         div_right_op,
  input  logic                          div_valid,
  input  logic [WORD_WIDTH-1:0]         div_quot,
  input  logic [WORD_WIDTH-1:0]         div_mod
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int TIMER_W = $clog2(TIMEOUT);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_DIVZERO = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [IDX_W-1:0]       last_reg, last_next;
  logic [IDX_W-1:0]       owner_reg, owner_next;
  logic [TIMER_W-1:0]     timer_reg, timer_next;
  logic [WORD_WIDTH-1:0]  left_reg, left_next;
  logic [WORD_WIDTH-1:0]  right_reg, right_next;
  logic [WORD_WIDTH-1:0]  quot_reg, quot_next;
  logic [WORD_WIDTH-1:0]  mod_reg, mod_next;
  logic [1:0]             err_reg, err_next;
  logic                   enable_reg, enable_next;
  logic [NUM_REQ-1:0]     resp_valid_reg, resp_valid_next;

  logic [WORD_WIDTH-1:0]  left_arr  [NUM_REQ];
  logic [WORD_WIDTH-1:0]  right_arr [NUM_REQ];
  logic                   grant_valid;
  logic [IDX_W-1:0]       grant_idx;
  logic [IDX_W-1:0]       cand;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign left_arr[gi]  = req_left[gi*WORD_WIDTH +: WORD_WIDTH];
      assign right_arr[gi] = req_right[gi*WORD_WIDTH +: WORD_WIDTH];
      assign req_ready[gi] = (state_reg == IDLE) && grant_valid &&
                             (grant_idx == IDX_W'(gi));
    end
  endgenerate

  // Scan downward so the last hit is the nearest requester after 'last'.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(last_reg) + 1 + k) % NUM_REQ);
      if (req_valid[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    owner_next = owner_reg;
    timer_next = timer_reg;
    left_next  = left_reg;
    right_next = right_reg;
    quot_next  = quot_reg;
    mod_next   = mod_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          owner_next = grant_idx;
          last_next  = grant_idx;
          left_next  = left_arr[grant_idx];
          right_next = right_arr[grant_idx];
          timer_next = '0;
          if (right_arr[grant_idx] == '0) begin
            quot_next  = '1;
            mod_next   = left_arr[grant_idx];
            err_next   = ERR_DIVZERO;
            state_next = RESP;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        // A result arriving on the watchdog's last cycle still counts.
        if (div_valid) begin
          quot_next  = div_quot;
          mod_next   = div_mod;
          err_next   = ERR_OK;
          state_next = RESP;
        end else if (timer_reg == TIMER_W'(TIMEOUT - 1)) begin
          quot_next  = '0;
          mod_next   = '0;
          err_next   = ERR_TIMEOUT;
          state_next = RESP;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready[owner_reg]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered versions of the decoded outputs keep them glitch-free.
  always_comb begin
    enable_next     = (state_next == BUSY);
    resp_valid_next = '0;
    if (state_next == RESP) resp_valid_next = NUM_REQ'(1) << owner_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_reg       <= IDX_W'(NUM_REQ - 1);
      owner_reg      <= '0;
      timer_reg      <= '0;
      left_reg       <= '0;
      right_reg      <= '0;
      quot_reg       <= '0;
      mod_reg        <= '0;
      err_reg        <= '0;
      enable_reg     <= 1'b0;
      resp_valid_reg <= '0;
    end else begin
      state_reg      <= state_next;
      last_reg       <= last_next;
      owner_reg      <= owner_next;
      timer_reg      <= timer_next;
      left_reg       <= left_next;
      right_reg      <= right_next;
      quot_reg       <= quot_next;
      mod_reg        <= mod_next;
      err_reg        <= err_next;
      enable_reg     <= enable_next;
      resp_valid_reg <= resp_valid_next;
    end
  end

  assign div_enable   = enable_reg;
  assign div_left_op  = left_reg;
  assign div_right_op = right_reg;
  assign resp_valid   = resp_valid_reg;
  assign resp_quot    = quot_reg;
  assign resp_mod     = mod_reg;
  assign resp_err     = err_reg;

endmodule

// File: tb/tb_division_arbiter.sv
// Bench for division_arbiter: behavioural DivisionUnit (latency LAT, optional
// stuck stub), response scoreboard, table vectors and multi-cycle sequences.
module tb_division_arbiter;
  localparam int W   = 8;
  localparam int N   = 4;
  localparam int TO  = 16;
  localparam int LAT = 4;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_left;
  logic [N*W-1:0] req_right;
  logic [N-1:0]   resp_valid;
  logic [N-1:0]   resp_ready;
  logic [W-1:0]   resp_quot;
  logic [W-1:0]   resp_mod;
  logic [1:0]     resp_err;
  logic           div_enable;
  logic [W-1:0]   div_left_op;
  logic [W-1:0]   div_right_op;
  logic           div_valid;
  logic [W-1:0]   div_quot;
  logic [W-1:0]   div_mod;

  logic           stub;
  int             unit_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         idx;
    logic [7:0] quot;
    logic [7:0] mod;
    logic [1:0] err;
  } exp_t;

  typedef struct {
    int         idx;
    logic [7:0] l;
    logic [7:0] r;
    logic [7:0] q;
    logic [7:0] m;
    logic [1:0] e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];

  division_arbiter #(.WORD_WIDTH(W), .NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_left(req_left), .req_right(req_right),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_quot(resp_quot), .resp_mod(resp_mod), .resp_err(resp_err),
    .div_enable(div_enable), .div_left_op(div_left_op), .div_right_op(div_right_op),
    .div_valid(div_valid), .div_quot(div_quot), .div_mod(div_mod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural DivisionUnit: result valid on the LAT-th enabled cycle.
  always @(posedge clk) begin
    if (div_enable) unit_cnt <= unit_cnt + 1;
    else            unit_cnt <= 0;
  end
  assign div_valid = div_enable && (unit_cnt == LAT - 1) && !stub;
  assign div_quot  = (div_right_op == 0) ? 8'hFF : div_left_op / div_right_op;
  assign div_mod   = (div_right_op == 0) ? div_left_op : div_left_op % div_right_op;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_resp(input int idx, input logic [7:0] q, input logic [7:0] m,
                             input logic [1:0] e);
    exp_t x;
    x.idx = idx; x.quot = q; x.mod = m; x.err = e;
    sb.push_back(x);
  endtask

  // Scoreboard: compare whenever a response handshake is about to happen.
  int   mon_o;
  exp_t mon_e;
  always begin
    @(negedge clk);
    #2;
    if (resp_valid != '0) begin
      check("resp_onehot", 32'($onehot(resp_valid)), 32'd1);
      if ((resp_valid & resp_ready) != '0) begin
        mon_o = -1;
        for (int i = 0; i < N; i++) if (resp_valid[i]) mon_o = i;
        if (sb.size() == 0) begin
          check("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("resp_owner", 32'(mon_o), 32'(mon_e.idx));
          check("resp_quot", 32'(resp_quot), 32'(mon_e.quot));
          check("resp_mod", 32'(resp_mod), 32'(mon_e.mod));
          check("resp_err", 32'(resp_err), 32'(mon_e.err));
          $display("resp: req %0d quot %0d mod %0d err %0b", mon_o, resp_quot, resp_mod, resp_err);
        end
      end
    end
  end

  // Returns at the falling edge just after the accepting edge (cycle T+1).
  task automatic issue(input int idx, input logic [7:0] l, input logic [7:0] r);
    logic ok;
    req_left[idx*W +: W]  = l;
    req_right[idx*W +: W] = r;
    req_valid[idx]        = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      #1;
      if (req_ready[idx]) ok = 1'b1;
      @(negedge clk);
    end
    req_valid[idx] = 1'b0;
    check("grant_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_done();
    logic done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      #3;
      done = (sb.size() == 0) && (resp_valid == '0);
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  // Raise several requests at once; optionally re-raise one after k accepts.
  task automatic run_batch(input logic [N-1:0] mask, input int rr_after, input int rr_idx,
                           input logic [7:0] rr_l, input logic [7:0] rr_r);
    logic [N-1:0] acc;
    int           accepts;
    logic         rr_done;
    logic         done;
    req_valid = mask;
    accepts   = 0;
    rr_done   = (rr_after < 0);
    done      = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      #1;
      check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      acc = req_valid & req_ready;
      @(negedge clk);
      req_valid = req_valid & ~acc;
      accepts   = accepts + $countones(acc);
      if (!rr_done && accepts == rr_after) begin
        req_left[rr_idx*W +: W]  = rr_l;
        req_right[rr_idx*W +: W] = rr_r;
        req_valid[rr_idx]        = 1'b1;
        rr_done                  = 1'b1;
      end
      done = rr_done && (req_valid == '0) && (sb.size() == 0) && (resp_valid == '0);
    end
    check("batch_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    reset      = 1'b1;
    req_valid  = '0;
    req_left   = '0;
    req_right  = '0;
    resp_ready = '1;
    stub       = 1'b0;

    vecs[0] = '{2,   7,   2,   3,   1, 2'b00};
    vecs[1] = '{1,   9,   0, 255,   9, 2'b01};
    vecs[2] = '{3, 200,   7,  28,   4, 2'b00};
    vecs[3] = '{0,   0,   5,   0,   0, 2'b00};
    vecs[4] = '{1, 255,   1, 255,   0, 2'b00};
    vecs[5] = '{2,  13,  13,   1,   0, 2'b00};
    vecs[6] = '{3,   0,   0, 255,   0, 2'b01};
    vecs[7] = '{0, 100,   9,  11,   1, 2'b00};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_div_enable", 32'(div_enable), 32'd0);
    check("rst_left_op", 32'(div_left_op), 32'd0);
    check("rst_right_op", 32'(div_right_op), 32'd0);
    check("rst_quot", 32'(resp_quot), 32'd0);
    check("rst_mod", 32'(resp_mod), 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single request 5/3 with latency check
    expect_resp(0, 8'd1, 8'd2, 2'b00);
    issue(0, 8'd5, 8'd3);
    #1;
    check("busy_enable", 32'(div_enable), 32'd1);
    check("busy_left_op", 32'(div_left_op), 32'd5);
    check("busy_right_op", 32'(div_right_op), 32'd3);
    check("busy_no_resp", 32'(resp_valid), 32'd0);
    #1;
    n = 0;
    while (resp_valid == '0 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("resp_latency", 32'(n), 32'(LAT));
    check("resp_enable_low", 32'(div_enable), 32'd0);
    wait_done();

    // Table vectors
    for (int v = 0; v < 8; v++) begin
      expect_resp(vecs[v].idx, vecs[v].q, vecs[v].m, vecs[v].e);
      issue(vecs[v].idx, vecs[v].l, vecs[v].r);
      wait_done();
    end

    // Divide-by-zero: response in T+1, unit never enabled
    expect_resp(1, 8'd255, 8'd9, 2'b01);
    issue(1, 8'd9, 8'd0);
    #1;
    check("dz_resp_valid", 32'(resp_valid), 32'b0010);
    check("dz_enable", 32'(div_enable), 32'd0);
    @(negedge clk);
    #1;
    check("dz_enable_after", 32'(div_enable), 32'd0);
    wait_done();

    // Timeout with a unit that never completes
    stub = 1'b1;
    expect_resp(1, 8'd0, 8'd0, 2'b10);
    issue(1, 8'd77, 8'd5);
    #2;
    n = 0;
    for (int g = 0; g < 100 && resp_valid == '0; g++) begin
      if (div_enable) n++;
      @(negedge clk);
      #2;
    end
    check("timeout_busy_cycles", 32'(n), 32'(TO));
    check("timeout_enable_low", 32'(div_enable), 32'd0);
    wait_done();
    stub = 1'b0;

    // Backpressure: owner holds resp_ready low, another requester waits
    resp_ready = '0;
    expect_resp(3, 8'd8, 8'd2, 2'b00);
    issue(3, 8'd50, 8'd6);
    for (int g = 0; g < 50 && resp_valid == '0; g++) @(negedge clk);
    req_left[1*W +: W]  = 8'd9;
    req_right[1*W +: W] = 8'd3;
    req_valid[1]        = 1'b1;
    expect_resp(1, 8'd3, 8'd0, 2'b00);
    resp_ready = 4'b0111;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("bp_resp_valid", 32'(resp_valid), 32'b1000);
      check("bp_quot", 32'(resp_quot), 32'd8);
      check("bp_mod", 32'(resp_mod), 32'd2);
      check("bp_err", 32'(resp_err), 32'd0);
      check("bp_no_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = '1;
    issue(1, 8'd9, 8'd3);
    wait_done();

    // Reset mid-BUSY discards the operation
    issue(2, 8'd40, 8'd3);
    @(negedge clk);
    #1;
    check("pre_rst_busy", 32'(div_enable), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_enable", 32'(div_enable), 32'd0);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_left_op", 32'(div_left_op), 32'd0);
    check("midrst_right_op", 32'(div_right_op), 32'd0);
    check("midrst_quot", 32'(resp_quot), 32'd0);
    check("midrst_mod", 32'(resp_mod), 32'd0);
    check("midrst_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Contention after reset: order 0,1,2,3, then 0 again after re-request
    for (int i = 0; i < N; i++) begin
      req_left[i*W +: W]  = 8'd20;
      req_right[i*W +: W] = 8'(i + 1);
    end
    expect_resp(0, 8'd20, 8'd0, 2'b00);
    expect_resp(1, 8'd10, 8'd0, 2'b00);
    expect_resp(2, 8'd6,  8'd2, 2'b00);
    expect_resp(3, 8'd5,  8'd0, 2'b00);
    expect_resp(0, 8'd7,  8'd1, 2'b00);
    run_batch(4'b1111, 2, 0, 8'd50, 8'd7);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/division_arbiter.md
# division_arbiter

Round-robin arbiter and sequencer that shares one `DivisionUnit` among `NUM_REQ` requesters. It accepts divide requests over per-requester valid/ready handshakes and drives the unit's `enable` and operand inputs. It captures `quot`/`mod` on the unit's `valid` and returns the result to the owning requester. Divide-by-zero is handled locally without starting the unit, and a watchdog aborts operations that never complete.

## Interface
- `WORD_WIDTH`, 8, operand/result width (matches the shared `DivisionUnit`)
- `NUM_REQ`, 4, number of requesters, ≥2
- `TIMEOUT`, 64, maximum BUSY cycles before abort, ≥2
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  NUM_REQ  per-requester request valid
- `req_ready`  out  NUM_REQ  per-requester accept, one-hot or zero
- `req_left`  in  NUM_REQ*WORD_WIDTH  dividends, requester i at bits [i*WORD_WIDTH +: WORD_WIDTH]
- `req_right`  in  NUM_REQ*WORD_WIDTH  divisors, same packing
- `resp_valid`  out  NUM_REQ  one-hot result valid to the owning requester
- `resp_ready`  in  NUM_REQ  per-requester result accept
- `resp_quot`  out  WORD_WIDTH  quotient
- `resp_mod`  out  WORD_WIDTH  remainder
- `resp_err`  out  2  00 ok, 01 divide-by-zero, 10 timeout
- `div_enable`  out  1  to `DivisionUnit.enable`
- `div_left_op`, `div_right_op`  out  WORD_WIDTH each  to the unit's operands
- `div_valid`  in  1  from `DivisionUnit.valid`
- `div_quot`, `div_mod`  in  WORD_WIDTH each  from the unit

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- Reset values: all outputs 0; round-robin pointer `last` = NUM_REQ-1, so requester 0 has first priority; owner, timer and latched operands/results are 0.
- **IDLE**
  - Grant the first `i` with `req_valid[i]`, scanning from `last+1` modulo NUM_REQ.
  - `req_ready[i]` is combinational: high only in IDLE, only for the granted `i`.
  - On handshake, latch `i` as owner, latch its operands, and set `last` = i.
  - If the divisor is non-zero, go to BUSY. If it is zero, go to RESP with `resp_quot` = all ones, `resp_mod` = dividend, err = 01. `div_enable` stays low.
- **BUSY**
  - `div_enable` = 1; `div_left_op`/`div_right_op` hold the latched operands, stable for the whole state.
  - Timer starts at 0 on entry and increments each BUSY cycle.
  - `div_valid` = 1 at an edge: capture `div_quot`/`div_mod`, err = 00, go to RESP.
  - Otherwise, timer = TIMEOUT-1 at an edge: quot = mod = 0, err = 10, go to RESP.
  - If both conditions hit on the same edge, `div_valid` wins.
- **RESP**
  - `div_enable` = 0; `resp_valid[owner]` = 1; result registers hold.
  - On `resp_ready[owner]`, go to IDLE. `resp_ready` of non-owners is ignored.
- Operand outputs are driven from the latch in every state. `div_enable` is low outside BUSY, so the unit always sees at least one low cycle (RESP) between operations.
- Requests arriving during BUSY/RESP wait; no `req_ready` is issued.
- `req_valid` dropped before handshake: no grant is made and the pointer is unchanged.
- Reset mid-operation: immediate return to IDLE with reset values; any in-flight result is discarded.

## Timing
- Accept at edge T. BUSY runs from T+1; `div_enable` rises in cycle T+1.
- Unit latency L (cycles of `div_enable` before `div_valid`): `resp_valid` rises in cycle T+1+L.
- Divide-by-zero: `resp_valid` in cycle T+1.
- Timeout: `resp_valid` in cycle T+1+TIMEOUT.
- If `resp_ready` is already high, the response completes the cycle it appears. The next accept is possible in the following cycle, giving a minimum period of L+2 cycles.
- `req_ready` is combinational from `req_valid` and state. All other outputs are registered.

## Test plan
- Single request, requester 0: 5/3 with the real `DivisionUnit` → `div_enable` high from T+1, `resp_valid[0]`, quot 1, mod 2, err 00. Then requester 2: 7/2 → quot 3, mod 1.
- Contention: all four raise `req_valid` at once (operands 20/i+1) → service order 0,1,2,3 with quotients 20, 10, 6, 5. Requester 0 re-requests during service of 1 → it is served after 3.
- Divide-by-zero: requester 1 sends 9/0 → `resp_valid[1]` at T+1, quot 255, mod 9, err 01, `div_enable` never rises.
- Timeout: a stub unit that never asserts `div_valid`, TIMEOUT=16 → exactly 16 BUSY cycles, then err 10, quot 0, mod 0, `div_enable` low.
- Backpressure: `resp_ready` held low 5 cycles → result and `resp_valid` stable, no new `req_ready`. The response completes on release.
- Reset asserted mid-BUSY → all outputs 0 immediately. The next request is granted to requester 0 first.
